// File: rtl/operand_skew_feeder.sv
// operand_skew_feeder
//
// Feeds one edge of the systolic PE array. One operand vector per cycle
// arrives from a buffer over valid/ready. Lane i is delayed by i extra
// cycles so that operands meet their partners on the array diagonal.
// Each start runs one burst of k_len vectors. The skew pipeline is then
// flushed with zeros, and done pulses for one cycle.
//
// Ports:
//   clk       - single clock, all logic on the rising edge
//   rst       - synchronous active-high reset, aborts any burst in flight
//   start     - begin a burst (only looked at while idle)
//   k_len     - burst length, captured when start is accepted
//   in_valid  - upstream vector valid
//   in_ready  - block accepts a vector this cycle (depends on state only)
//   in_vec    - input vector, lane i at bits [i*DW +: DW]
//   out_vec   - skewed operands to the array edge, same lane packing
//   out_fire  - one-cycle pulse aligned with lane 0 of the first vector
//   busy      - high whenever the block is not idle
//   done      - one-cycle pulse at burst completion
module operand_skew_feeder #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int KW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_vec,
  output logic [LANES*DW-1:0] out_vec,
  output logic                out_fire,
  output logic                busy,
  output logic                done
);

  // drain_cnt must be able to hold the value LANES
  localparam int DCW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   accept_cnt;
  logic [DCW-1:0]  drain_cnt;
  logic            accept;
  logic            last_accept;
  logic            drain_end;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (accept_cnt == (k_reg - KW'(1)));
  // The drain lasts LANES cycles, so lane LANES-1 of the final vector
  // has left the chain when the block reaches DONE.
  assign drain_end   = (drain_cnt == DCW'(LANES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A zero-length burst skips STREAM and DRAIN.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (k_len != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (last_accept) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State-decoded outputs. in_ready must never depend on in_valid.
  always_comb begin
    in_ready = (state == STREAM);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // Burst bookkeeping. The burst length is latched at start. Accepts are
  // counted, and bubbles are not. The drain counter runs only in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg      <= '0;
      accept_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      if (state == IDLE && start && k_len != '0) begin
        k_reg      <= k_len;
        accept_cnt <= '0;
      end else if (accept) begin
        accept_cnt <= accept_cnt + KW'(1);
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DCW'(1);
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  // The fire pulse is registered, so it lines up with lane 0 of the
  // first accepted vector, which also appears one cycle after its accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_fire <= 1'b0;
    end else begin
      out_fire <= accept && (accept_cnt == '0);
    end
  end

  // Skew chains. Lane i holds i+1 registers. Every chain shifts on every
  // cycle in every state, and zeros enter whenever no vector is accepted.
  // This keeps the lanes aligned through bubbles and during the drain.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] chain [0:i];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          chain[j] <= '0;
        end
      end else begin
        chain[0] <= accept ? in_vec[i*DW +: DW] : '0;
        for (int j = 1; j <= i; j++) begin
          chain[j] <= chain[j-1];
        end
      end
    end

    assign out_vec[i*DW +: DW] = chain[i];
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// tb_operand_skew_feeder
//
// Drives operand_skew_feeder with LANES=4 through the directed scenarios
// first, then through random traffic. The reference model records which
// vector (or zero) entered the array on each cycle. It predicts lane i
// at cycle c as the entry from cycle c-1-i. Burst-level events (fire,
// done, busy, ready) are predicted from burst start and accept times.
module tb_operand_skew_feeder;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int KW    = 16;
  localparam int VW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_vec;
  logic [VW-1:0] out_vec;
  logic          out_fire;
  logic          busy;
  logic          done;

  operand_skew_feeder #(
    .LANES(LANES),
    .DW   (DW),
    .KW   (KW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k_len   (k_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vec  (in_vec),
    .out_vec (out_vec),
    .out_fire(out_fire),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [VW-1:0] hist [16];
  int            m_remaining = 0;
  int            done_at     = -1;
  int            fire_at     = -1;
  bit            m_busy      = 1'b0;
  bit            m_first     = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expLane(input int lane);
    logic [VW-1:0] v;
    v = hist[(cyc - 1 - lane) & 15];
    return v[lane*DW +: DW];
  endfunction

  // One clock cycle: drive inputs, check the current outputs against the
  // model, advance the model with this cycle's inputs, then step the clock.
  task automatic applyStimulus(input bit r, input bit s, input logic [KW-1:0] k,
                               input bit v, input logic [VW-1:0] vec);
    bit acc;
    rst      = r;
    start    = s;
    k_len    = k;
    in_valid = v;
    in_vec   = vec;
    if (check_en) begin
      checkOutput("in_ready", in_ready, m_remaining > 0);
      checkOutput("busy", busy, m_busy);
      checkOutput("done", done, cyc == done_at);
      checkOutput("out_fire", out_fire, cyc == fire_at);
      for (int i = 0; i < LANES; i++) begin
        checkOutput($sformatf("lane%0d", i), out_vec[i*DW +: DW], expLane(i));
      end
    end
    if (r) begin
      foreach (hist[j]) hist[j] = '0;
      m_remaining = 0;
      m_busy      = 1'b0;
      m_first     = 1'b0;
      done_at     = -1;
      fire_at     = -1;
    end else begin
      acc = v && (m_remaining > 0);
      hist[cyc & 15] = acc ? vec : '0;
      if (acc) begin
        if (m_first) begin
          fire_at = cyc + 1;
          m_first = 1'b0;
        end
        m_remaining--;
        if (m_remaining == 0) done_at = cyc + LANES + 1;
      end
      if (s && !m_busy) begin
        m_busy = 1'b1;
        if (k != '0) begin
          m_remaining = int'(k);
          m_first     = 1'b1;
        end else begin
          done_at = cyc + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!r && (cyc - 1 == done_at)) m_busy = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, '0);
  endtask

  // Let the model return to idle (bounded), then flush the skew chains.
  task automatic settle();
    for (int n = 0; n < 40 && m_busy; n++) applyStimulus(0, 0, '0, 0, '0);
    idleCycles(LANES + 1);
  endtask

  localparam logic [VW-1:0] V0 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [VW-1:0] V1 = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [VW-1:0] V2 = {8'd12, 8'd11, 8'd10, 8'd9};

  initial begin
    foreach (hist[j]) hist[j] = '0;
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; in_vec = '0;
    applyStimulus(1, 0, '0, 0, '0);
    applyStimulus(1, 0, '0, 0, '0);
    check_en = 1'b1;
    idleCycles(2);

    // Basic burst of three with valid held high
    applyStimulus(0, 1, 16'd3, 0, '0);
    applyStimulus(0, 0, '0, 1, V0);
    applyStimulus(0, 0, '0, 1, V1);
    applyStimulus(0, 0, '0, 1, V2);
    settle();

    // Same burst with one bubble after the first vector
    applyStimulus(0, 1, 16'd3, 0, '0);
    applyStimulus(0, 0, '0, 1, V0);
    applyStimulus(0, 0, '0, 0, V2);
    applyStimulus(0, 0, '0, 1, V1);
    applyStimulus(0, 0, '0, 1, V2);
    settle();

    // Zero-length burst with valid high; nothing should be accepted
    applyStimulus(0, 1, 16'd0, 1, V1);
    applyStimulus(0, 0, '0, 1, V1);
    applyStimulus(0, 0, '0, 1, V1);
    settle();

    // Back-to-back bursts with start held high
    for (int i = 0; i < 24; i++) applyStimulus(0, 1, 16'd2, 1, VW'($urandom));
    settle();

    // Reset mid-stream after two of five accepts, then a fresh burst
    applyStimulus(0, 1, 16'd5, 0, '0);
    applyStimulus(0, 0, '0, 1, V0);
    applyStimulus(0, 0, '0, 1, V1);
    applyStimulus(1, 0, '0, 1, V2);
    idleCycles(2);
    applyStimulus(0, 1, 16'd2, 0, '0);
    applyStimulus(0, 0, '0, 1, V2);
    applyStimulus(0, 0, '0, 1, V0);
    settle();

    // Random traffic: random starts, lengths, bubbles and occasional resets
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom % 60) == 0, ($urandom % 4) == 0,
                    KW'($urandom_range(0, 6)), ($urandom % 3) != 0,
                    VW'($urandom));
    end
    settle();

    // Maximum burst length with continuous valid
    applyStimulus(0, 1, 16'hFFFF, 0, '0);
    for (int i = 0; i < 65535; i++) applyStimulus(0, 0, '0, 1, VW'($urandom));
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
